// File: rtl/cnn_stream_classifier.sv
// Streaming 3x3 conv -> ReLU -> global sum pool -> single-output dense classifier.
// Weights are programmed through a write port while idle; pixels use a valid/ready handshake.
module cnn_stream_classifier #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int PIX_W       = 4,
    parameter int NUM_FILTERS = 2,
    parameter int W_W         = 4,
    parameter int ACC_W       = 20,
    parameter int CONF_HI     = 1000,
    parameter int CONF_LO     = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    input  logic             wt_wr_en,
    input  logic [5:0]       wt_addr,
    input  logic [7:0]       wt_data,
    output logic             busy,
    output logic             result_valid,
    output logic             classification,
    output logic [7:0]       confidence,
    output logic [31:0]      logit
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DW    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int SUM_W = PIX_W + W_W + 5;
    localparam int EW    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;

    localparam logic signed [ACC_W-1:0] FEAT_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0]    FEAT_MAX_EXT = EW'(FEAT_MAX);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DENSE, OUT} state_t;

    state_t state, state_next;

    logic             accept, restart, last_pix;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [31:0]      addr;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] win [3][3];
    logic             win_valid;

    logic signed [W_W-1:0]   conv_w   [NUM_FILTERS][9];
    logic signed [7:0]       dense_w  [NUM_FILTERS];
    logic signed [7:0]       bias;
    logic signed [ACC_W-1:0] feature      [NUM_FILTERS];
    logic signed [ACC_W-1:0] feature_next [NUM_FILTERS];
    logic signed [SUM_W-1:0] conv_sum     [NUM_FILTERS];
    logic signed [EW-1:0]    feat_ext     [NUM_FILTERS];

    logic [DW-1:0]      dcnt;
    logic signed [31:0] acc, prod;
    logic signed [32:0] acc_wide, mag;
    logic [7:0]         conf_next;

    assign pixel_ready = (state == LOAD);
    assign busy        = (state != IDLE);
    assign restart     = frame_start && (state == IDLE || state == LOAD);
    // A restart wins over a coincident pixel so the new frame starts clean.
    assign accept      = pixel_valid && pixel_ready && !frame_start;
    assign last_pix    = (int'(row) == IMG_H - 1) && (int'(col) == IMG_W - 1);
    assign addr        = 32'(wt_addr);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = LOAD;
            LOAD:    if (accept && last_pix) state_next = DRAIN;
            DRAIN:   state_next = DENSE;
            DENSE:   if (int'(dcnt) == NUM_FILTERS - 1) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bias <= '0;
            for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                dense_w[f] <= '0;
                for (int unsigned k = 0; k < 9; k++) conv_w[f][k] <= '0;
            end
        end else if (wt_wr_en && state == IDLE) begin
            for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
                for (int unsigned k = 0; k < 9; k++)
                    if (addr == f * 9 + k) conv_w[f][k] <= wt_data[W_W-1:0];
                if (addr == 9 * NUM_FILTERS + f) dense_w[f] <= wt_data;
            end
            if (addr == 10 * NUM_FILTERS) bias <= wt_data;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            for (int unsigned i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++) win[r][c] <= '0;
        end else begin
            win_valid <= 1'b0;
            if (restart) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1[col];
                win[1][2] <= lb0[col];
                win[2][2] <= pixel_in;
                lb1[col]  <= lb0[col];
                lb0[col]  <= pixel_in;
                win_valid <= (int'(row) >= 2) && (int'(col) >= 2);
                if (int'(col) == IMG_W - 1) begin
                    col <= '0;
                    row <= (int'(row) == IMG_H - 1) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned f = 0; f < NUM_FILTERS; f++) begin
            conv_sum[f] = '0;
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    conv_sum[f] = conv_sum[f]
                        + SUM_W'(signed'({1'b0, win[r][c]})) * SUM_W'(conv_w[f][r*3+c]);
            feat_ext[f] = EW'(feature[f]) + EW'(conv_sum[f]);
            if (conv_sum[f] > 0) begin
                if (feat_ext[f] > FEAT_MAX_EXT) feature_next[f] = FEAT_MAX;
                else                            feature_next[f] = feat_ext[f][ACC_W-1:0];
            end else begin
                feature_next[f] = feature[f];
            end
        end
    end

    always_comb begin
        prod     = 32'(feature[dcnt]) * 32'(dense_w[dcnt]);
        acc_wide = 33'(acc);
        mag      = (acc_wide < 0) ? -acc_wide : acc_wide;
        if (mag >= 33'(CONF_HI))      conf_next = 8'd95;
        else if (mag >= 33'(CONF_LO)) conf_next = 8'd80;
        else                          conf_next = 8'd60;
    end

    // Results are registered on leaving OUT, which gives the NUM_FILTERS+3 latency.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned f = 0; f < NUM_FILTERS; f++) feature[f] <= '0;
            dcnt           <= '0;
            acc            <= '0;
            result_valid   <= 1'b0;
            classification <= 1'b0;
            confidence     <= '0;
            logit          <= '0;
        end else begin
            result_valid <= 1'b0;
            if (restart) begin
                for (int unsigned f = 0; f < NUM_FILTERS; f++) feature[f] <= '0;
            end else if (win_valid) begin
                for (int unsigned f = 0; f < NUM_FILTERS; f++) feature[f] <= feature_next[f];
            end
            case (state)
                DRAIN: begin
                    acc  <= 32'(bias);
                    dcnt <= '0;
                end
                DENSE: begin
                    acc  <= acc + prod;
                    dcnt <= dcnt + 1'b1;
                end
                OUT: begin
                    result_valid   <= 1'b1;
                    logit          <= acc;
                    classification <= (acc > 0);
                    confidence     <= conf_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_classifier.sv
// Scoreboard bench: drivers push hand-computed results, per-DUT monitors pop on result_valid.
// Instance b uses ACC_W=10 to exercise feature saturation.
module tb_cnn_stream_classifier;

    typedef struct {
        longint logit;
        int     cls;
        int     conf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic [3:0] pixel_in = '0;
    logic       pixel_valid = 1'b0;
    logic       wt_wr_en = 1'b0;
    logic [5:0] wt_addr = '0;
    logic [7:0] wt_data = '0;
    logic       sel = 1'b0;

    logic        fs_a, fs_b, we_a, we_b;
    logic        ready_a, busy_a, rv_a, cls_a;
    logic        ready_b, busy_b, rv_b, cls_b;
    logic [7:0]  conf_a, conf_b;
    logic [31:0] logit_a, logit_b;

    int   cyc = 0;
    int   acc_cyc = 0;
    int   passed = 0;
    int   total = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    assign fs_a = frame_start & ~sel;
    assign fs_b = frame_start & sel;
    assign we_a = wt_wr_en & ~sel;
    assign we_b = wt_wr_en & sel;

    cnn_stream_classifier dut_a (
        .clk(clk), .rst_n(rst), .frame_start(fs_a), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(ready_a), .wt_wr_en(we_a),
        .wt_addr(wt_addr), .wt_data(wt_data), .busy(busy_a), .result_valid(rv_a),
        .classification(cls_a), .confidence(conf_a), .logit(logit_a)
    );

    cnn_stream_classifier #(.ACC_W(10)) dut_b (
        .clk(clk), .rst_n(rst), .frame_start(fs_b), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(ready_b), .wt_wr_en(we_b),
        .wt_addr(wt_addr), .wt_data(wt_data), .busy(busy_b), .result_valid(rv_b),
        .classification(cls_b), .confidence(conf_b), .logit(logit_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Sampled mid-cycle, so the cycle holding result_valid is index cyc+1.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rv_a) begin
            if (q_a.size() == 0) chk("unexpected_result_a", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("logit_a", longint'($signed(logit_a)), e.logit);
                chk("class_a", longint'(cls_a), e.cls);
                chk("conf_a", longint'(conf_a), e.conf);
                chk("latency_a", cyc + 1 - acc_cyc, 5);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rv_b) begin
            if (q_b.size() == 0) chk("unexpected_result_b", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("logit_b", longint'($signed(logit_b)), e.logit);
                chk("class_b", longint'(cls_b), e.cls);
                chk("conf_b", longint'(conf_b), e.conf);
                chk("latency_b", cyc + 1 - acc_cyc, 5);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wt_addr  = 6'(a);
        wt_data  = 8'(d);
        wt_wr_en = 1'b1;
        tick;
        wt_wr_en = 1'b0;
    endtask

    task automatic start_frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    // wr_at: index of the pixel that carries a (to be dropped) dense_w0 write, -1 for none.
    task automatic feed(input int pix, input int n, input bit gaps, input int wr_at);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b0;
            if (gaps && $urandom_range(0, 1) == 1) tick;
            pixel_in    = 4'(pix);
            pixel_valid = 1'b1;
            if (i == wr_at) begin
                wt_addr  = 6'd18;
                wt_data  = 8'd50;
                wt_wr_en = 1'b1;
            end
            tick;
            acc_cyc     = cyc;
            wt_wr_en    = 1'b0;
            pixel_valid = 1'b0;
        end
    endtask

    task automatic expect_a(input longint l, input int c, input int f);
        q_a.push_back('{logit: l, cls: c, conf: f});
    endtask

    task automatic wait_done;
        for (int i = 0; i < 40; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            tick;
        end
        chk("pending_results", q_a.size() + q_b.size(), 0);
        q_a.delete();
        q_b.delete();
    endtask

    task automatic frame_a(input int pix, input bit gaps, input int wr_at,
                           input longint l, input int c, input int f);
        expect_a(l, c, f);
        start_frame;
        chk("busy_in_load", longint'(busy_a), 1);
        feed(pix, 64, gaps, wr_at);
        wait_done;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_rv", longint'(rv_a), 0);
        chk("rst_class", longint'(cls_a), 0);
        chk("rst_conf", longint'(conf_a), 0);
        chk("rst_logit", longint'(logit_a), 0);
        chk("rst_ready", longint'(ready_a), 0);
        rst = 1'b0;
        tick;

        // centre tap only: 36 windows of 5 -> 180
        wr(4, 1);
        wr(18, 1);
        frame_a(5, 1'b0, -1, 180, 1, 60);

        wr(18, 8'hFF);
        wr(20, 10);
        frame_a(5, 1'b0, -1, -170, 0, 60);

        wr(18, 8'hF8);
        frame_a(5, 1'b0, -1, -1430, 0, 95);

        // f1 all -1: every window negative, ReLU leaves logit at bias 0
        wr(4, 0);
        wr(18, 0);
        wr(20, 0);
        for (int k = 9; k < 18; k++) wr(k, 8'h0F);
        wr(19, 100);
        frame_a(15, 1'b0, -1, 0, 0, 60);

        wr(4, 1);
        wr(18, 1);
        pixel_valid = 1'b1;
        #1;
        chk("ready_idle", longint'(ready_a), 0);
        pixel_valid = 1'b0;
        frame_a(5, 1'b1, 20, 180, 1, 60);

        // confidence boundaries: 504-4 = 500, 1008-8 = 1000
        wr(20, 8'hFC);
        frame_a(14, 1'b0, -1, 500, 1, 80);
        wr(18, 2);
        wr(20, 8'hF8);
        frame_a(14, 1'b0, -1, 1000, 1, 95);

        // saturating instance: window sum 945 clips feature at 511
        sel = 1'b1;
        for (int k = 0; k < 9; k++) wr(k, 7);
        wr(18, 1);
        q_b.push_back('{logit: 511, cls: 1, conf: 80});
        start_frame;
        feed(15, 64, 1'b0, -1);
        wait_done;
        sel = 1'b0;

        start_frame;
        feed(9, 30, 1'b0, -1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy_a), 0);
        chk("midrst_ready", longint'(ready_a), 0);
        chk("midrst_class", longint'(cls_a), 0);
        chk("midrst_conf", longint'(conf_a), 0);
        chk("midrst_logit", longint'(logit_a), 0);
        chk("midrst_logit_b", longint'(logit_b), 0);
        tick;
        tick;
        rst = 1'b0;
        tick;

        wr(4, 1);
        wr(18, 1);
        expect_a(180, 1, 60);
        start_frame;
        feed(9, 40, 1'b0, -1);
        start_frame;
        feed(5, 64, 1'b0, -1);
        wait_done;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
